interval_timer_ctrl: RTL and testbench



---
 rtl/interval_timer_pkg.sv | 17 +
 rtl/timer_count_core.sv | 31 +++
 rtl/interval_timer_ctrl.sv | 108 ++++++++++
 tb/tb_interval_timer_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_timer_pkg.sv
// Shared types and defaults for the interval timer controller and its counter core.
package interval_timer_pkg;

  localparam int TIMER_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } timer_state_e;

  function automatic logic is_busy(input timer_state_e s);
    return (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/timer_count_core.sv
// WIDTH-bit synchronous counter with clear, enable and a terminal compare against period.
module timer_count_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic at_term;

  assign at_term = (count == period);
  assign tc      = en && at_term;

  // Wrapping at period (never past it) keeps count+1 free of overflow even at full scale.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (at_term) count <= '0;
      else         count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: owns counter clear/enable, sequences run/pause/done, raises tc, irq and overrun.
module interval_timer_ctrl
  import interval_timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic             irq,
  output logic             overrun,
  output timer_state_e     state_dbg
);

  timer_state_e     state, state_nxt;
  logic [WIDTH-1:0] period_q;
  logic             periodic_q;
  logic             start_cmd;
  logic             ctr_clr;
  logic             ctr_en;
  logic             ctr_tc;

  // Command priority: stop > start > pause.
  assign start_cmd = start && !stop;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else if (start) begin
      state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (pause)                     state_nxt = ST_PAUSE;
          else if (ctr_tc && !periodic_q) state_nxt = ST_DONE;
        end
        ST_PAUSE: begin
          if (!pause) state_nxt = ST_RUN;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Leaving PAUSE costs one held cycle: the count only advances from RUN.
  always_comb begin
    busy    = is_busy(state);
    ctr_clr = stop || start;
    ctr_en  = (state == ST_RUN) && !stop && !start && !pause;
  end

  timer_count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .clr    (ctr_clr),
    .en     (ctr_en),
    .period (period_q),
    .count  (count),
    .tc     (ctr_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      period_q   <= '0;
      periodic_q <= 1'b0;
    end else if (cfg_load && !busy) begin
      period_q   <= cfg_period;
      periodic_q <= cfg_periodic;
    end
  end

  // A tc that coincides with irq_ack keeps irq set; overrun only when irq was pending and unacked.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tc_pulse <= 1'b0;
      irq      <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      tc_pulse <= ctr_tc;
      if (ctr_tc) begin
        irq <= 1'b1;
        if (irq && !irq_ack) overrun <= 1'b1;
      end else begin
        if (irq_ack)   irq     <= 1'b0;
        if (start_cmd) overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic vs a behavioural model.
module tb_interval_timer_ctrl;
  import interval_timer_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cfg_load = 1'b0;
  logic [W-1:0] cfg_period = '0;
  logic         cfg_periodic = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         pause = 1'b0;
  logic         irq_ack = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         tc_pulse;
  logic         irq;
  logic         overrun;
  timer_state_e state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  interval_timer_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_load     (cfg_load),
    .cfg_period   (cfg_period),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .irq_ack      (irq_ack),
    .count        (count),
    .busy         (busy),
    .tc_pulse     (tc_pulse),
    .irq          (irq),
    .overrun      (overrun),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Behavioural model: timer described as "active / held / phase within period".
  typedef struct {
    bit active;
    bit held;
    int phase;
    int per;
    bit periodic;
    bit tc;
    bit irq;
    bit ovr;
  } model_t;

  model_t m = '{default: 0};

  function automatic model_t model_step(input model_t c);
    model_t n;
    n = c;
    n.tc = 1'b0;
    if (!rst) begin
      n = '{default: 0};
    end else begin
      if (cfg_load && !c.active) begin
        n.per      = int'(cfg_period);
        n.periodic = cfg_periodic;
      end
      if (stop) begin
        n.active = 0; n.held = 0; n.phase = 0;
      end else if (start) begin
        n.active = 1; n.held = 0; n.phase = 0; n.ovr = 0;
      end else if (c.active && c.held) begin
        if (!pause) n.held = 0;
      end else if (c.active) begin
        if (pause) n.held = 1;
        else if (c.phase == c.per) begin
          n.phase = 0;
          n.tc    = 1;
          if (!c.periodic) n.active = 0;
        end else n.phase = c.phase + 1;
      end
      if (n.tc) begin
        if (c.irq && !irq_ack) n.ovr = 1;
        n.irq = 1;
      end else if (irq_ack) n.irq = 0;
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_step(m);

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // scoreboard: every cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_count",    int'(count),    m.phase);
      check("model_busy",     int'(busy),     int'(m.active));
      check("model_tc_pulse", int'(tc_pulse), int'(m.tc));
      check("model_irq",      int'(irq),      int'(m.irq));
      check("model_overrun",  int'(overrun),  int'(m.ovr));
    end
  end

  // driver tasks
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_cmds();
    cfg_load = 0; start = 0; stop = 0; irq_ack = 0;
  endtask

  task automatic load_start(input int p, input bit periodic);
    cfg_load = 1; cfg_period = W'(p); cfg_periodic = periodic; start = 1;
    cyc();
    clear_cmds();
  endtask

  initial begin
    rst = 0;
    cyc(3);
    rst = 1;
    chk_en = 1;
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_state", int'(state_dbg), int'(ST_IDLE));

    // P=3 periodic, config and start in the same cycle
    load_start(3, 1);
    check("p3_start_count", int'(count), 0);
    cyc(3);
    check("p3_count3", int'(count), 3);
    cyc();
    check("p3_tc4", int'(tc_pulse), 1);
    check("p3_irq4", int'(irq), 1);
    cfg_load = 1; cfg_period = 4'd7;
    cyc();
    clear_cmds();
    cyc(3);
    check("p3_ignored_load_tc8", int'(tc_pulse), 1);
    check("p3_overrun8", int'(overrun), 1);
    irq_ack = 1;
    cyc();
    clear_cmds();
    check("ack_irq_clear", int'(irq), 0);
    check("ack_overrun_kept", int'(overrun), 1);
    start = 1;
    cyc();
    clear_cmds();
    check("restart_ovr_clear", int'(overrun), 0);
    cyc(7);
    irq_ack = 1;
    cyc();
    clear_cmds();
    check("tc_ack_irq", int'(irq), 1);
    check("tc_ack_ovr", int'(overrun), 0);
    stop = 1; start = 1;
    cyc();
    clear_cmds();
    check("stop_start_state", int'(state_dbg), int'(ST_IDLE));
    check("stop_start_count", int'(count), 0);

    // P=5 one-shot
    load_start(5, 0);
    cyc(5);
    check("os_count5", int'(count), 5);
    cyc();
    check("os_tc6", int'(tc_pulse), 1);
    check("os_done", int'(state_dbg), int'(ST_DONE));
    cyc(20);
    check("os_quiet_busy", int'(busy), 0);

    // pause mid-period
    load_start(3, 1);
    cyc(2);
    pause = 1;
    cyc();
    check("pause_state", int'(state_dbg), int'(ST_PAUSE));
    check("pause_count", int'(count), 2);
    cyc();
    pause = 0;
    cyc();
    check("resume_count", int'(count), 2);
    cyc();
    check("resume_tc6", int'(tc_pulse), 0);
    cyc();
    check("resume_tc7", int'(tc_pulse), 1);

    // reset mid-run at count 2
    start = 1;
    cyc();
    clear_cmds();
    cyc(2);
    rst = 0;
    cyc();
    rst = 1;
    check("midrst_count", int'(count), 0);
    check("midrst_irq", int'(irq), 0);
    check("midrst_state", int'(state_dbg), int'(ST_IDLE));

    // P=0 periodic and one-shot, then full scale
    load_start(0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("p0_tc", int'(tc_pulse), 1);
    end
    stop = 1;
    cyc();
    clear_cmds();
    load_start(0, 0);
    cyc();
    check("p0_os_tc", int'(tc_pulse), 1);
    check("p0_os_busy", int'(busy), 0);
    load_start(15, 1);
    cyc(15);
    check("pmax_count", int'(count), 15);
    cyc();
    check("pmax_tc", int'(tc_pulse), 1);
    check("pmax_wrap", int'(count), 0);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) != 0);
      stop         = ($urandom_range(0, 39) == 0);
      start        = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      cfg_load     = ($urandom_range(0, 9) == 0);
      cfg_period   = W'($urandom_range(0, 15));
      cfg_periodic = 1'($urandom_range(0, 1));
      irq_ack      = ($urandom_range(0, 7) == 0);
      cyc();
    end
    clear_cmds();
    pause = 0;
    rst = 1;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
